pll_reset_seq: RTL and testbench

- Sits directly downstream of the 219 MHz iCE40 PLL wrapper and runs on its output clock.
- Turns the raw PLL `locked` flag into a clean, debounced, synchronous reset and a `ready` flag for the fast TX datapath.
- Generates a one-cycle sample-rate strobe (`tick`) that is enabled only while the domain is out of reset.
- Detects sustained lock loss, re-enters reset, and keeps a sticky loss flag and a relock counter for status readback.

---
 rtl/pll_reset_seq.sv | 157 +++++++++++++++
 tb/tb_pll_reset_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and reset sequencer for the fast TX clock domain.
// Turns the raw, asynchronous PLL lock flag into a debounced reset/ready pair, a RUN-gated tick and lock-loss status.
module pll_reset_seq #(
  parameter int LOCK_CYCLES = 4096,
  parameter int RST_HOLD    = 64,
  parameter int LOSS_FILTER = 8,
  parameter int DIV         = 219,
  parameter int CNT_W       = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  input  logic       lost_clr,
  output logic       rst_out,
  output logic       ready,
  output logic       tick,
  output logic       lock_lost,
  output logic [7:0] relock_count,
  output logic [1:0] state
);

  localparam int LOSS_W = $clog2(LOSS_FILTER + 1);
  localparam int DIV_W  = $clog2(DIV);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_QUALIFY   = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_sync;
  logic [CNT_W-1:0]    r_cnt;
  logic [LOSS_W-1:0]   r_loss;
  logic [DIV_W-1:0]    r_div;
  logic                r_rst_out;
  logic                r_ready;
  logic                r_tick;
  logic                r_lock_lost;
  logic [7:0]          r_relock;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [LOSS_W-1:0]   w_loss_nxt;
  logic [DIV_W-1:0]    w_div_nxt;
  logic                w_tick_nxt;
  logic                w_loss_event;
  logic                w_run_stay;
  logic                w_lk;

  assign w_lk = r_sync[1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_loss_nxt   = '0;
    w_loss_event = 1'b0;
    unique case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lk) begin
          w_state_nxt = ST_QUALIFY;
          w_cnt_nxt   = '0;
        end
      end
      ST_QUALIFY: begin
        if (!w_lk) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        // A single unlocked cycle here aborts silently; it is not a filtered loss.
        if (!w_lk) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(RST_HOLD - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!w_lk) begin
          if (r_loss == LOSS_W'(LOSS_FILTER - 1)) begin
            w_state_nxt  = ST_WAIT_LOCK;
            w_loss_event = 1'b1;
          end else begin
            w_loss_nxt = r_loss + LOSS_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase

    // Divider only runs while RUN is both current and next, so it restarts at 0 on every entry.
    w_run_stay = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
    w_div_nxt  = '0;
    w_tick_nxt = 1'b0;
    if (w_run_stay) begin
      if (r_div == DIV_W'(DIV - 1)) begin
        w_tick_nxt = 1'b1;
      end else begin
        w_div_nxt = r_div + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_sync      <= 2'b00;
      r_state     <= ST_WAIT_LOCK;
      r_cnt       <= '0;
      r_loss      <= '0;
      r_div       <= '0;
      r_rst_out   <= 1'b1;
      r_ready     <= 1'b0;
      r_tick      <= 1'b0;
      r_lock_lost <= 1'b0;
      r_relock    <= '0;
    end else begin
      r_sync    <= {r_sync[0], locked};
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_loss    <= w_loss_nxt;
      r_div     <= w_div_nxt;
      r_rst_out <= (w_state_nxt != ST_RUN);
      r_ready   <= (w_state_nxt == ST_RUN);
      r_tick    <= w_tick_nxt;
      // A new loss outranks a simultaneous clear.
      if (w_loss_event) begin
        r_lock_lost <= 1'b1;
      end else if (lost_clr) begin
        r_lock_lost <= 1'b0;
      end
      if (w_loss_event && (r_relock != 8'hFF)) begin
        r_relock <= r_relock + 8'd1;
      end
    end
  end

  assign rst_out      = r_rst_out;
  assign ready        = r_ready;
  assign tick         = r_tick;
  assign lock_lost    = r_lock_lost;
  assign relock_count = r_relock;
  assign state        = r_state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with LOCK_CYCLES=16, RST_HOLD=8, LOSS_FILTER=4, DIV=5.
// Each vector drives inputs just after an edge, advances n edges, then compares every output.
module tb_pll_reset_seq;

  logic       clock;
  logic       reset;
  logic       locked;
  logic       lost_clr;
  logic       rst_out;
  logic       ready;
  logic       tick;
  logic       lock_lost;
  logic [7:0] relock_count;
  logic [1:0] state;

  int n_tests;
  int n_failed;

  pll_reset_seq #(
    .LOCK_CYCLES(16),
    .RST_HOLD   (8),
    .LOSS_FILTER(4),
    .DIV        (5),
    .CNT_W      (5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .locked      (locked),
    .lost_clr    (lost_clr),
    .rst_out     (rst_out),
    .ready       (ready),
    .tick        (tick),
    .lock_lost   (lock_lost),
    .relock_count(relock_count),
    .state       (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       reset;
    logic       locked;
    logic       lost_clr;
    int         n;
    logic [1:0] e_state;
    logic       e_rst;
    logic       e_ready;
    logic       e_tick;
    logic       e_lost;
    logic [7:0] e_relock;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string name, input logic [1:0] e_state, input logic e_rst,
                           input logic e_ready, input logic e_tick, input logic e_lost,
                           input logic [7:0] e_relock);
    check({name, ".state"}, 32'(state), 32'(e_state));
    check({name, ".rst_out"}, 32'(rst_out), 32'(e_rst));
    check({name, ".ready"}, 32'(ready), 32'(e_ready));
    check({name, ".tick"}, 32'(tick), 32'(e_tick));
    check({name, ".lock_lost"}, 32'(lock_lost), 32'(e_lost));
    check({name, ".relock_count"}, 32'(relock_count), 32'(e_relock));
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    reset    = 1'b1;
    locked   = 1'b0;
    lost_clr = 1'b0;

    //                name         rst lk clr  n   st rst rdy tk lost rel
    vecs.push_back('{"reset",       1, 0, 0,  3, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{"pwr_hold25",  0, 1, 0, 26, 2, 1, 0, 0, 0, 0});
    vecs.push_back('{"pwr_run26",   0, 1, 0,  1, 3, 0, 1, 0, 0, 0});
    vecs.push_back('{"pwr_e30",     0, 1, 0,  4, 3, 0, 1, 0, 0, 0});
    vecs.push_back('{"tick1_e31",   0, 1, 0,  1, 3, 0, 1, 1, 0, 0});
    vecs.push_back('{"tick_off32",  0, 1, 0,  1, 3, 0, 1, 0, 0, 0});
    vecs.push_back('{"tick2_e36",   0, 1, 0,  4, 3, 0, 1, 1, 0, 0});
    vecs.push_back('{"glitch_low",  0, 0, 0,  3, 3, 0, 1, 0, 0, 0});
    vecs.push_back('{"glitch_t41",  0, 1, 0,  2, 3, 0, 1, 1, 0, 0});
    vecs.push_back('{"glitch_t46",  0, 1, 0,  5, 3, 0, 1, 1, 0, 0});
    vecs.push_back('{"loss_pre",    0, 0, 0,  5, 3, 0, 1, 1, 0, 0});
    vecs.push_back('{"loss_exit",   0, 0, 0,  1, 0, 1, 0, 0, 1, 1});
    vecs.push_back('{"loss_wait",   0, 0, 0,  3, 0, 1, 0, 0, 1, 1});
    vecs.push_back('{"relock_hold", 0, 1, 0, 26, 2, 1, 0, 0, 1, 1});
    vecs.push_back('{"relock_run",  0, 1, 0,  1, 3, 0, 1, 0, 1, 1});
    vecs.push_back('{"clr_alone",   0, 1, 1,  1, 3, 0, 1, 0, 0, 1});
    vecs.push_back('{"clr_idle",    0, 1, 0,  1, 3, 0, 1, 0, 0, 1});
    vecs.push_back('{"loss2_pre",   0, 0, 0,  5, 3, 0, 1, 0, 0, 1});
    vecs.push_back('{"set_vs_clr",  0, 0, 1,  1, 0, 1, 0, 0, 1, 2});
    vecs.push_back('{"loss2_wait",  0, 0, 0,  2, 0, 1, 0, 0, 1, 2});
    vecs.push_back('{"bounce_q",    0, 1, 0, 10, 1, 1, 0, 0, 1, 2});
    vecs.push_back('{"bounce_low",  0, 0, 0,  1, 1, 1, 0, 0, 1, 2});
    vecs.push_back('{"bounce_back", 0, 1, 0,  2, 0, 1, 0, 0, 1, 2});
    vecs.push_back('{"bounce_hold", 0, 1, 0, 24, 2, 1, 0, 0, 1, 2});
    vecs.push_back('{"bounce_run",  0, 1, 0,  1, 3, 0, 1, 0, 1, 2});
    vecs.push_back('{"run_e3",      0, 1, 0,  3, 3, 0, 1, 0, 1, 2});
    vecs.push_back('{"mid_reset",   1, 1, 0,  1, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{"rerun_hold",  0, 1, 0, 26, 2, 1, 0, 0, 0, 0});
    vecs.push_back('{"rerun_run",   0, 1, 0,  1, 3, 0, 1, 0, 0, 0});

    @(posedge clock);
    #1;
    foreach (vecs[i]) begin
      reset    = vecs[i].reset;
      locked   = vecs[i].locked;
      lost_clr = vecs[i].lost_clr;
      clk_n(vecs[i].n);
      check_all(vecs[i].name, vecs[i].e_state, vecs[i].e_rst, vecs[i].e_ready,
                vecs[i].e_tick, vecs[i].e_lost, vecs[i].e_relock);
    end

    // Tick cadence over 20 cycles after RUN entry: high exactly on every 5th.
    for (int k = 1; k <= 20; k++) begin
      clk_n(1);
      check($sformatf("cadence%0d.tick", k), 32'(tick), 32'((k % 5) == 0));
      check($sformatf("cadence%0d.state", k), 32'(state), 32'd3);
    end

    // Reset landing on the edge that would have produced a tick.
    clk_n(4);
    reset = 1'b1;
    clk_n(1);
    check_all("reset_on_tick", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

    // One-cycle lock drop while in HOLD aborts without counting a loss.
    reset  = 1'b0;
    locked = 1'b1;
    clk_n(20);
    check("hold_entry.state", 32'(state), 32'd2);
    locked = 1'b0;
    clk_n(1);
    check("hold_drop.state", 32'(state), 32'd2);
    locked = 1'b1;
    clk_n(2);
    check_all("hold_abort", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    clk_n(1);
    check("hold_requalify.state", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
